axis_tlast_gen: RTL and testbench
=================================

Name: axis_tlast_gen

Overview:
- Sits directly downstream of the accelerator's 64-bit result stream (two 32-bit results per beat) and in front of the DMA S2MM port.
- The accelerator never asserts TLAST. This block counts result beats against a software-programmed length and tags the final beat with TLAST so the DMA can close the transfer.
- It also decouples backpressure through a 2-entry skid buffer and reports busy/done status.

Parameters:
- DATA_W, 64, stream data width; TSTRB width is DATA_W/8.
- CNT_W, 16, width of the beat-length and beat-counter fields.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches len and arms a packet.
- len  in  CNT_W  number of beats in the packet; sampled only on start.
- busy  out  1  high from an accepted start until the TLAST beat leaves.
- done  out  1  one-cycle pulse in the cycle after the TLAST beat handshake on M side.
- S_AXIS_TVALID  in  1  upstream result valid.
- S_AXIS_TDATA  in  DATA_W  upstream result data.
- S_AXIS_TSTRB  in  DATA_W/8  upstream strobes, passed through.
- S_AXIS_TREADY  out  1  ready to upstream; driven from a register.
- M_AXIS_TVALID  out  1  to DMA.
- M_AXIS_TDATA  out  DATA_W  to DMA.
- M_AXIS_TSTRB  out  DATA_W/8  to DMA.
- M_AXIS_TLAST  out  1  to DMA.
- M_AXIS_TREADY  in  1  from DMA.
- stall_cnt  out  32  count of cycles with M_AXIS_TVALID=1 and M_AXIS_TREADY=0 (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, both buffer entries invalid, state IDLE, counters 0.
- Reset is honoured mid-packet: buffered beats are discarded and no done pulse is generated.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - S_AXIS_TREADY=0; upstream beats are not accepted.
  - start with len!=0 latches len, clears in_cnt, and goes to RUN; busy=1 next cycle.
  - start with len==0 stays in IDLE and pulses done the next cycle; busy stays 0.
- RUN:
  - S_AXIS_TREADY = registered (buffer not full and in_cnt != len).
  - Each S handshake pushes {TDATA, TSTRB, last} into the skid buffer and increments in_cnt.
  - last = (in_cnt == len-1), computed at push time.
  - When the last beat is pushed, go to DRAIN; TREADY deasserts in the following cycle.
- DRAIN:
  - TREADY=0.
  - Stay until the tagged beat completes its M handshake, then go to IDLE.
  - busy falls and done pulses in the same cycle (the cycle after the handshake).
- start while busy is ignored; len is not re-sampled.
- Skid buffer:
  - 2-entry FIFO; M side presents the head entry.
  - Zero-bubble: a full-rate stream with M_AXIS_TREADY held high sustains 1 beat/cycle.
  - Latency is 1 cycle from S handshake to M_AXIS_TVALID.
  - Simultaneous push and pop while holding 1 entry keeps occupancy at 1.
  - TREADY is registered, so it may be low for one extra cycle after space frees; this costs no data.
- M_AXIS_TDATA/TSTRB/TLAST are stable while TVALID=1 and TREADY=0.
- Arithmetic: in_cnt is CNT_W bits and cannot wrap, because acceptance stops at len. len=2^CNT_W-1 is legal.

Optional Feature:
- Macro: TLAST_GEN_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared on reset and on an accepted start.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Package tiny_dnn_axis_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - localparams DATA_W_DEF=64 and CNT_W_DEF=16;
  - buffer entry struct {data, strb, last}.
- Sub-module axis_skid2: generic 2-entry valid/ready FIFO carrying the entry struct, with async active-low reset. The top level holds the FSM and counters.

Test Plan:
- len=4, start, 4 beats back-to-back, M_TREADY=1 → 4 M beats on consecutive cycles; TLAST only on beat 4; done pulses 1 cycle after beat 4; busy low afterwards.
- len=3, upstream presents 5 beats → only 3 accepted; S_AXIS_TREADY=0 from the cycle after the 3rd handshake; beats 4–5 stay pending upstream.
- len=8, M_TREADY toggling 1,0,0,1 → data order preserved; no beat lost or duplicated; output stable during stalls; TLAST on beat 8; stall_cnt=number of stalled valid cycles (macro on), 0 (macro off).
- start with len=0 → done pulse next cycle; busy never rises; S_AXIS_TREADY stays 0.
- len=6, AXIS_ARESETN driven low after 3 beats → all outputs 0 immediately; no done; a fresh start with len=2 then completes normally with TLAST on beat 2.
- Second start issued mid-packet (len=5 → start len=2 at beat 2) → ignored; TLAST on beat 5.

Source files
------------

// File: rtl/axis_tlast_gen_pkg.sv
// ---------------------------------------------------------------------------
// tiny_dnn_axis_pkg
// Shared types for the accelerator result-stream TLAST generator.
//   state_t    : packet sequencer states (IDLE, RUN, DRAIN)
//   DATA_W_DEF : default stream data width (two 32-bit results per beat)
//   CNT_W_DEF  : default width of the beat-length / beat-counter fields
//   beat_t     : one skid-buffer entry {data, strb, last} at default widths
// ---------------------------------------------------------------------------
package tiny_dnn_axis_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]   data;
    logic [DATA_W_DEF/8-1:0] strb;
    logic                    last;
  } beat_t;

endpackage

// File: rtl/axis_tlast_gen_if.sv
// ---------------------------------------------------------------------------
// axis_if
// AXI4-Stream bundle used on both sides of axis_tlast_gen.
//   tvalid / tready : handshake
//   tdata  [DATA_W]   : payload
//   tstrb  [DATA_W/8] : byte strobes
//   tlast             : end of packet (unused by the upstream accelerator)
// Modports:
//   master : drives valid/data/strb/last, samples ready
//   slave  : samples valid/data/strb/last, drives ready
// ---------------------------------------------------------------------------
import tiny_dnn_axis_pkg::*;

interface axis_if #(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_tlast_gen_skid2.sv
// ---------------------------------------------------------------------------
// axis_skid2
// Generic 2-entry valid/ready FIFO carrying an entry of type T.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid / s_ready : write side; s_ready is a register (not full)
//   s_data            : entry written on s_valid & s_ready
//   m_valid / m_ready : read side; head entry presented on m_data
// One cycle from write to m_valid. With m_ready held high the FIFO sits at
// one entry and sustains one transfer per cycle. The head entry only changes
// on a pop, so m_data is stable while m_valid=1 and m_ready=0.
// ---------------------------------------------------------------------------
import tiny_dnn_axis_pkg::*;

module axis_skid2 #(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_valid,
  output logic s_ready,
  input  T     s_data,
  output logic m_valid,
  input  logic m_ready,
  output T     m_data
);

  logic [1:0] cnt_reg, cnt_next;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic       s_ready_reg;
  logic       push, pop;

  assign push    = s_valid & s_ready_reg;
  assign pop     = m_valid & m_ready;
  assign s_ready = s_ready_reg;
  assign m_valid = (cnt_reg != 2'd0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // Ready is computed from the post-update occupancy so a freed slot is
  // advertised on the very next cycle and full-rate streaming has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= 2'd0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      s_ready_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      s_ready_reg <= (cnt_next != 2'd2);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      T entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= s_data;
        end
      end
    end
  endgenerate

  assign m_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

endmodule

// File: rtl/axis_tlast_gen.sv
// ---------------------------------------------------------------------------
// axis_tlast_gen
// Counts accelerator result beats against a programmed length and tags the
// final beat with TLAST for the DMA S2MM port. Backpressure is decoupled by
// a 2-entry skid buffer (axis_skid2).
//   AXIS_ACLK, AXIS_ARESETN : clock, asynchronous active-low reset
//   start, len              : arm a packet of len beats (len sampled on start)
//   busy                    : accepted start until the TLAST beat has left
//   done                    : one-cycle pulse after the TLAST handshake, or
//                             the cycle after a start with len==0
//   S_AXIS (slave)          : upstream results, no TLAST
//   M_AXIS (master)         : downstream to DMA, with TLAST
//   stall_cnt               : cycles with M valid and not ready
// Build option: define TLAST_GEN_STALL_CNT_EN to generate the saturating
// stall counter; otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
import tiny_dnn_axis_pkg::*;

module axis_tlast_gen #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  axis_if.slave            S_AXIS,
  axis_if.master           M_AXIS,
  output logic [31:0]      stall_cnt
);

  // Entry layout matches beat_t but follows this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } entry_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] in_cnt_reg, in_cnt_next;
  logic             tready_reg, tready_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             skid_s_ready;
  logic             skid_m_valid;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             s_hs;
  logic             m_hs;
  logic             last_beat;

  // Both terms are flops, so upstream ready has no combinational path
  // from any input.
  assign S_AXIS.tready = tready_reg & skid_s_ready;
  assign s_hs          = S_AXIS.tvalid & S_AXIS.tready;
  assign m_hs          = M_AXIS.tvalid & M_AXIS.tready;

  // len_reg is non-zero whenever a push can happen, so len_reg-1 never wraps.
  assign last_beat = (in_cnt_reg == (len_reg - CNT_W'(1)));

  always_comb begin
    push_entry      = '0;
    push_entry.data = S_AXIS.tdata;
    push_entry.strb = S_AXIS.tstrb;
    push_entry.last = last_beat;
  end

  axis_skid2 #(
    .T(entry_t)
  ) u_skid (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .s_valid (S_AXIS.tvalid & tready_reg),
    .s_ready (skid_s_ready),
    .s_data  (push_entry),
    .m_valid (skid_m_valid),
    .m_ready (M_AXIS.tready),
    .m_data  (head_entry)
  );

  assign M_AXIS.tvalid = skid_m_valid;
  assign M_AXIS.tdata  = head_entry.data;
  assign M_AXIS.tstrb  = head_entry.strb;
  assign M_AXIS.tlast  = head_entry.last;

  assign busy = busy_reg;
  assign done = done_reg;

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    in_cnt_next = in_cnt_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_next    = len;
            in_cnt_next = '0;
            busy_next   = 1'b1;
            state_next  = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (s_hs) begin
          in_cnt_next = in_cnt_reg + CNT_W'(1);
          if (last_beat) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Only the tagged beat carries last; once it leaves the buffer is empty.
        if (m_hs && M_AXIS.tlast) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
    tready_next = (state_next == RUN) && (in_cnt_next != len_next);
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      in_cnt_reg <= '0;
      tready_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      in_cnt_reg <= in_cnt_next;
      tready_reg <= tready_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

`ifdef TLAST_GEN_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic        start_accept;

  assign start_accept = start & (state_reg == IDLE);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      stall_cnt_reg <= 32'd0;
    end else if (start_accept) begin
      stall_cnt_reg <= 32'd0;
    end else if (M_AXIS.tvalid && !M_AXIS.tready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axis_tlast_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_tlast_gen
// Directed packets with random payloads; the reference is a queue of the
// upstream beats: the first len of them must appear downstream in order,
// TLAST on beat len, done one cycle after that handshake.
// ---------------------------------------------------------------------------
module tb_axis_tlast_gen;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic [31:0]   stall_cnt;

  axis_if #(.DATA_W(DW)) s_if ();
  axis_if #(.DATA_W(DW)) m_if ();

  always #5 clk = ~clk;

  axis_tlast_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .S_AXIS       (s_if),
    .M_AXIS       (m_if),
    .stall_cnt    (stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] up_d[$];
  logic [7:0]  up_s[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " m_tvalid"}, m_if.tvalid, 0);
    chk({name, " m_tdata"}, m_if.tdata, 0);
    chk({name, " m_tstrb"}, m_if.tstrb, 0);
    chk({name, " m_tlast"}, m_if.tlast, 0);
    chk({name, " s_tready"}, s_if.tready, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " stall_cnt"}, stall_cnt, 0);
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready
  // and random gaps between upstream beats. mid_at: issue start(len=2) once
  // when that many beats have been accepted. rst_at: assert reset instead.
  task automatic run_packet(input int plen, input int n_up, input int rmode,
                            input int mid_at, input int rst_at, input string name);
    int acc = 0;
    int out = 0;
    int stalls = 0;
    int cyc = 0;
    int first_m = -1;
    int last_m = -1;
    bit done_exp, busy_exp, done_next;
    bit hold = 0;
    bit prev_stall = 0;
    bit mid_done = 0;
    bit s_hs, m_hs;
    logic [63:0] hd;
    logic [7:0]  hs;
    logic        hl;
    logic [63:0] exp_stall;

    up_d.delete();
    up_s.delete();
    for (int i = 0; i < n_up; i++) begin
      up_d.push_back({$urandom, $urandom});
      up_s.push_back(8'($urandom_range(1, 255)));
    end

    start = 1'b1;
    len = CW'(plen);
    s_if.tvalid = (n_up > 0);
    if (n_up > 0) begin
      s_if.tdata = up_d[0];
      s_if.tstrb = up_s[0];
      hold = 1;
    end
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    done_exp = (plen == 0);
    busy_exp = (plen != 0);
    done_next = 0;

    while (1) begin
      chk({name, " done"}, done, done_exp);
      chk({name, " busy"}, busy, busy_exp);
      if (!busy_exp || acc >= plen) chk({name, " s_tready_low"}, s_if.tready, 0);
      if (prev_stall) begin
        chk({name, " hold_valid"}, m_if.tvalid, 1);
        chk({name, " hold_data"}, m_if.tdata, hd);
        chk({name, " hold_strb"}, m_if.tstrb, hs);
        chk({name, " hold_last"}, m_if.tlast, hl);
      end
      if (done_exp) break;
      if (cyc > 400) begin
        checks++;
        errors++;
        $error("FAIL %s timeout: beats_out=%0d expected=%0d", name, out, plen);
        break;
      end
      if (rst_at >= 0 && acc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero({name, " in_reset"});
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({name, " no_done_after_reset"}, done, 0);
        chk({name, " idle_after_reset"}, busy, 0);
        chk({name, " empty_after_reset"}, m_if.tvalid, 0);
        return;
      end

      if (mid_at >= 0 && acc == mid_at && !mid_done) begin
        start = 1'b1;
        len = CW'(2);
        mid_done = 1;
      end else begin
        start = 1'b0;
      end

      case (rmode)
        0: m_if.tready = 1'b1;
        1: m_if.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase

      if (acc < n_up) begin
        if (!hold) s_if.tvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_if.tdata = up_d[acc];
        s_if.tstrb = up_s[acc];
      end else begin
        s_if.tvalid = 1'b0;
      end

      s_hs = s_if.tvalid && s_if.tready;
      m_hs = m_if.tvalid && m_if.tready;
      if (m_hs) begin
        chk({name, " beat_in_range"}, out < plen, 1);
        if (out < plen) begin
          chk({name, " m_tdata"}, m_if.tdata, up_d[out]);
          chk({name, " m_tstrb"}, m_if.tstrb, up_s[out]);
          chk({name, " m_tlast"}, m_if.tlast, out == plen - 1);
          if (out == plen - 1) done_next = 1;
        end
        if (first_m < 0) first_m = cyc;
        last_m = cyc;
        out++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      if (prev_stall) begin
        stalls++;
        hd = m_if.tdata;
        hs = m_if.tstrb;
        hl = m_if.tlast;
      end
      if (s_hs) acc++;
      hold = s_if.tvalid && !s_hs;

      @(posedge clk); @(negedge clk);
      cyc++;
      done_exp = done_next;
      if (done_next) busy_exp = 0;
      done_next = 0;
    end

    start = 1'b0;
    chk({name, " beats_out"}, out, plen);
    chk({name, " beats_accepted"}, acc, plen);
`ifdef TLAST_GEN_STALL_CNT_EN
    exp_stall = 64'(stalls);
`else
    exp_stall = 64'd0;
`endif
    chk({name, " stall_cnt"}, stall_cnt, exp_stall);
    if (rmode == 0 && plen > 0) chk({name, " full_rate"}, last_m - first_m, plen - 1);

    @(posedge clk); @(negedge clk);
    chk({name, " done_one_cycle"}, done, 0);
    chk({name, " busy_after"}, busy, 0);
    chk({name, " s_tready_after"}, s_if.tready, 0);
    $display("packet %s len=%0d beats_out=%0d accepted=%0d stalls=%0d", name, plen, out, acc, stalls);
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    run_packet(4, 4, 0, -1, -1, "len4_fullrate");
    run_packet(3, 5, 0, -1, -1, "len3_excess");
    run_packet(8, 8, 1, -1, -1, "len8_toggle");
    run_packet(0, 2, 0, -1, -1, "len0");
    run_packet(6, 6, 1, -1, 3, "len6_reset");
    run_packet(2, 2, 0, -1, -1, "len2_after_reset");
    run_packet(5, 5, 0, 2, -1, "len5_midstart");
    run_packet(1, 2, 0, -1, -1, "len1");
    for (int k = 0; k < 4; k++) begin
      int pl;
      pl = $urandom_range(1, 20);
      run_packet(pl, pl + 2, 2, -1, -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
